// File: rtl/sfixed_divider_if.sv
// Handshake bundle for the iterative signed fixed-point divider.
// The operand side is valid/ready. The result side holds its value until out_ready.
interface sfixed_divider_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int OUT_W = 9
) ();
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic             overflow;
    logic             div_zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, overflow, div_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, overflow, div_zero
    );
endinterface

// File: rtl/sfixed_divider.sv
// Iterative signed sfixed divider that computes out = a / b.
// It runs one restoring shift-subtract step per clock and truncates toward zero with saturation.
module sfixed_divider #(
    parameter int A_LEFT    = 3,
    parameter int A_RIGHT   = 4,
    parameter int B_LEFT    = 3,
    parameter int B_RIGHT   = 4,
    parameter int OUT_LEFT  = 4,
    parameter int OUT_RIGHT = 4
) (
    input logic             clk,
    input logic             rst,
    sfixed_divider_if.slave bus
);
    localparam int A_W   = A_LEFT + A_RIGHT + 1;
    localparam int B_W   = B_LEFT + B_RIGHT + 1;
    localparam int OUT_W = OUT_LEFT + OUT_RIGHT + 1;
    localparam int SH    = OUT_RIGHT + B_RIGHT - A_RIGHT;
    localparam int DW    = A_W + SH;
    localparam int CW    = $clog2(DW);
    localparam int RW    = (DW > OUT_W) ? DW + 1 : OUT_W + 1;

    localparam logic [RW-1:0]    MAX_EXT = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [RW-1:0]    LIM_EXT = {{(RW-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    generate
        if (SH < 0) begin : g_bad_params
            $error("sfixed_divider: OUT_RIGHT + B_RIGHT must be >= A_RIGHT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [B_W-1:0]   b_mag;
    logic [DW-1:0]    dq;
    logic [B_W-1:0]   rem;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic [OUT_W-1:0] out_r;
    logic             ovf_r;
    logic             dz_r;

    logic             accept;
    logic             b_zero;
    logic [A_W-1:0]   a_mag_in;
    logic [B_W-1:0]   b_mag_in;
    logic [B_W-1:0]   shifted;
    logic [B_W:0]     trial;
    logic             qbit;
    logic [B_W-1:0]   rem_nxt;
    logic [DW-1:0]    q_nxt;
    logic [RW-1:0]    q_ext;
    logic [RW-1:0]    q_neg;
    logic [OUT_W-1:0] res;
    logic             res_ovf;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_r;
    assign bus.overflow  = ovf_r;
    assign bus.div_zero  = dz_r;

    assign accept = bus.in_valid && bus.in_ready;
    assign b_zero = (bus.b == '0);

    // The magnitude of the most negative operand still fits as an unsigned value.
    assign a_mag_in = bus.a[A_W-1] ? A_W'(-bus.a) : bus.a;
    assign b_mag_in = bus.b[B_W-1] ? B_W'(-bus.b) : bus.b;

    // The remainder stays below |b|, so the shifted remainder fits in B_W bits.
    assign shifted = {rem[B_W-2:0], dq[DW-1]};
    assign trial   = {1'b0, shifted} - {1'b0, b_mag};
    assign qbit    = !trial[B_W];
    assign rem_nxt = qbit ? trial[B_W-1:0] : shifted;
    assign q_nxt   = {dq[DW-2:0], qbit};
    assign q_ext   = RW'(q_nxt);
    assign q_neg   = -q_ext;

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        res     = q_ext[OUT_W-1:0];
        res_ovf = 1'b0;
        if (!sign) begin
            if (q_ext > MAX_EXT) begin
                res     = MAX_OUT;
                res_ovf = 1'b1;
            end
        end else if (q_ext > LIM_EXT) begin
            res     = MIN_OUT;
            res_ovf = 1'b1;
        end else begin
            res = q_neg[OUT_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = b_zero ? DONE : CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_mag <= '0;
            dq    <= '0;
            rem   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            out_r <= '0;
            ovf_r <= 1'b0;
            dz_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        b_mag <= b_mag_in;
                        dq    <= DW'(a_mag_in) << SH;
                        rem   <= '0;
                        cnt   <= CW'(DW - 1);
                        sign  <= bus.a[A_W-1] ^ bus.b[B_W-1];
                        if (b_zero) begin
                            out_r <= bus.a[A_W-1] ? MIN_OUT : (bus.a != '0) ? MAX_OUT : '0;
                            ovf_r <= 1'b0;
                            dz_r  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dq  <= q_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        out_r <= res;
                        ovf_r <= res_ovf;
                        dz_r  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sfixed_divider.sv
// Self-checking bench for sfixed_divider. It uses a directed vector table and hand-written handshake and reset sequences.
// It also checks random operands against an integer-arithmetic reference model.
module tb_sfixed_divider;
    localparam int SH      = 4;
    localparam int LAT     = 13;
    localparam int OUT_MAX = 255;
    localparam int OUT_MIN = -256;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] out;
        logic       ovf;
        logic       dz;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sfixed_divider_if #(.A_W(8), .B_W(8), .OUT_W(9)) bus ();

    sfixed_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [8:0] o, output logic ovf, output logic dz);
        int ai, bi, q;
        ai  = int'($signed(a));
        bi  = int'($signed(b));
        ovf = 1'b0;
        dz  = 1'b0;
        if (bi == 0) begin
            dz = 1'b1;
            q  = (ai > 0) ? OUT_MAX : (ai < 0) ? OUT_MIN : 0;
        end else begin
            q = (ai * (1 << SH)) / bi;
            if (q > OUT_MAX) begin q = OUT_MAX; ovf = 1'b1; end
            if (q < OUT_MIN) begin q = OUT_MIN; ovf = 1'b1; end
        end
        o = 9'(q);
    endfunction

    // Presents one operand pair and returns at the first falling edge where out_valid is seen.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, output int lat);
        int k;
        k = 0;
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_take", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv);
        logic [8:0] eo;
        logic       eovf, edz;
        int         lat;
        model(av, bv, eo, eovf, edz);
        issue(av, bv, lat);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), edz ? 32'd1 : 32'(LAT));
        check({tag, "_out"}, 32'(bus.out), 32'(eo));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(eovf));
        check({tag, "_div_zero"}, 32'(bus.div_zero), 32'(edz));
        release_result();
    endtask

    initial begin
        vec_t       vecs[11];
        int         lat;
        int         seen;
        logic [8:0] held;

        vecs[0]  = '{8'h20, 8'h08, 9'h040, 1'b0, 1'b0};
        vecs[1]  = '{8'hD0, 8'h20, 9'h1E8, 1'b0, 1'b0};
        vecs[2]  = '{8'h10, 8'h30, 9'h005, 1'b0, 1'b0};
        vecs[3]  = '{8'hF0, 8'h30, 9'h1FB, 1'b0, 1'b0};
        vecs[4]  = '{8'h7F, 8'h01, 9'h0FF, 1'b1, 1'b0};
        vecs[5]  = '{8'h80, 8'h01, 9'h100, 1'b1, 1'b0};
        vecs[6]  = '{8'h30, 8'h00, 9'h0FF, 1'b0, 1'b1};
        vecs[7]  = '{8'hD0, 8'h00, 9'h100, 1'b0, 1'b1};
        vecs[8]  = '{8'h00, 8'h00, 9'h000, 1'b0, 1'b1};
        vecs[9]  = '{8'h80, 8'h08, 9'h100, 1'b0, 1'b0};
        vecs[10] = '{8'h00, 8'hF0, 9'h000, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_div_zero", 32'(bus.div_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].dz ? 32'd1 : 32'(LAT));
            check($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].out));
            check($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_div_zero", i), 32'(bus.div_zero), 32'(vecs[i].dz));
            release_result();
        end

        // Back-pressure: the result must stay frozen while the consumer stalls.
        issue(8'h10, 8'h30, lat);
        held = bus.out;
        check("bp_first_out", 32'(held), 32'h005);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out !== held || !bus.out_valid || bus.in_ready) seen++;
        end
        check("bp_stall_stable", 32'(seen), 32'd0);
        release_result();
        check("bp_out_holds", 32'(bus.out), 32'h005);
        run_op("bp_next", 8'hD0, 8'h20);

        // in_valid with fresh operands during CALC must not disturb the running divide.
        bus.a = 8'h20;
        bus.b = 8'h08;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 8'h7F;
        bus.b = 8'h01;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check("busy_ignore_latency", 32'(lat), 32'(LAT));
        check("busy_ignore_out", 32'(bus.out), 32'h040);
        release_result();

        // Reset in the middle of CALC discards the pending result.
        bus.a = 8'h20;
        bus.b = 8'h08;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_out", 32'(bus.out), 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.in_ready || bus.out_valid) seen++;
        end
        check("abort_held_idle", 32'(seen), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op("after_abort", 8'hF0, 8'h30);

        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
